// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller for the RV32I five-stage core.
// Define CTRL_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              ex_load_i,
    input  logic [4:0]        ex_rd_addr_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic              id_rs1_re_i,
    input  logic              id_rs2_re_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o,
    output logic              bus_err_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t            state;
    logic [WC_W-1:0]   wait_cnt;
    logic              mem_stall;
    logic              load_use;

    // Holds drop in the cycle mem_ready_i arrives, so a completing access never stalls.
    assign mem_stall = !mem_ready_i &&
                       ((state == MEM_WAIT) || (state == RUN && mem_req_i));

    assign load_use = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_re_i && id_rs1_addr_i == ex_rd_addr_i) ||
                       (id_rs2_re_i && id_rs2_addr_i == ex_rd_addr_i));

    always_comb begin
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        jump_flag_o   = 1'b0;
        jump_addr_o   = 32'd0;
        // Outputs are forced quiet while reset is asserted, even mid-stall.
        if (!rst) begin
            hold_pc_o = 1'b0;
        end else if (state == ERR || mem_stall) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
        end else if (jump_flag_i) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            jump_flag_o   = 1'b1;
            jump_addr_o   = jump_addr_i;
        end else if (load_use) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            bus_err_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req_i && !mem_ready_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                        state     <= ERR;
                        bus_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ERR: state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_if_id_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule
